// File: rtl/pio_pkg.sv
// Shared constants for the PIO blocks: register offsets, edge-select encodings
// and a helper for sizing the debounce counter.
package pio_pkg;

  localparam int BUS_W = 32;

  typedef logic [BUS_W-1:0] bus_word_t;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter must be able to hold DEBOUNCE_CYCLES-1; keep at least one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input pin: two-flop synchronizer followed by a counting debounce filter
// whose stable output flips only after DEBOUNCE_CYCLES consecutive disagreements.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic stable_o
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any agreement with the stable value restarts the count, so glitches
  // shorter than DEBOUNCE_CYCLES never reach the output.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/pio_input_capture.sv
// Memory-mapped input PIO: debounced pin data, edge capture with write-1-to-clear,
// and a maskable level interrupt on a zero-wait-state word bus.
module pio_input_capture
  import pio_pkg::*;
#(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic             wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pin
      pio_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (in_port[gi]),
        .stable_o(stable[gi])
      );
    end
  endgenerate

  assign rise = stable & ~stable_dly_q;
  assign fall = ~stable & stable_dly_q;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_edge_rise
      assign edge_hit = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
      assign edge_hit = fall;
    end else begin : g_edge_any
      assign edge_hit = rise | fall;
    end
  endgenerate

  generate
    if (WIDTH < BUS_W) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = &{1'b0, writedata[BUS_W-1:WIDTH]};
    end
  endgenerate

  assign wr_en = chipselect & ~write_n;

  // New edges are OR-ed in after the clear so a simultaneous set wins.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGECAP)) begin
      clr = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr) | edge_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_dly_q <= '0;
      mask_q       <= '0;
      edgecap_q    <= '0;
    end else begin
      stable_dly_q <= stable;
      mask_q       <= mask_d;
      edgecap_q    <= edgecap_d;
    end
  end

  assign irq = |(edgecap_q & mask_q);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = BUS_W'(stable);
      ADDR_IRQMASK: readdata = BUS_W'(mask_q);
      ADDR_EDGECAP: readdata = BUS_W'(edgecap_q);
      default:      readdata = '0;
    endcase
  end

endmodule
